// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction-memory loader.
// Holds the loader state encoding and word framing constant.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        HI,
        LO,
        CHK,
        RUN,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory and releases the
// processor only after a complete frame with a matching checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              im_wr,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_data,
    output logic              proc_reset,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   FULL_N   = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam int                HI_W     = 8 * (BYTES_PER_WORD - 1);

    state_t            state_q;
    state_t            state_d;
    logic              xfer;
    logic              bad_cnt;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        xor_q;
    logic [HI_W-1:0]   hi_q;

    assign in_ready = (state_q == CNT) || (state_q == HI) ||
                      (state_q == LO)  || (state_q == CHK);
    assign xfer     = in_valid && in_ready;

    assign done       = (state_q == RUN);
    assign error      = (state_q == ERR);
    assign proc_reset = !(state_q == RUN);

    // COUNT of zero encodes a full memory image
    assign bad_cnt = int'(in_byte) > (1 << ADDR_W);
    assign n_words = (in_byte == 8'd0) ? FULL_N : (ADDR_W+1)'(in_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RUN, ERR: begin
                if (start) state_d = CNT;
            end
            CNT: begin
                if (xfer) state_d = bad_cnt ? ERR : HI;
            end
            HI: begin
                if (xfer) state_d = LO;
            end
            LO: begin
                if (xfer) state_d = (rem_q == REM_ONE) ? CHK : HI;
            end
            CHK: begin
                if (xfer) state_d = (in_byte == xor_q) ? RUN : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_wr   <= 1'b0;
            im_addr <= '0;
            im_data <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            xor_q   <= '0;
            hi_q    <= '0;
        end else begin
            im_wr <= 1'b0;
            unique case (state_q)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        addr_q <= '0;
                        xor_q  <= '0;
                    end
                end
                CNT: begin
                    if (xfer) begin
                        rem_q  <= n_words;
                        addr_q <= '0;
                        xor_q  <= in_byte;
                    end
                end
                HI: begin
                    if (xfer) begin
                        hi_q  <= in_byte;
                        xor_q <= xor_q ^ in_byte;
                    end
                end
                LO: begin
                    if (xfer) begin
                        im_wr   <= 1'b1;
                        im_addr <= addr_q;
                        im_data <= DATA_W'({hi_q, in_byte});
                        addr_q  <= addr_q + ADDR_ONE;
                        rem_q   <= rem_q - REM_ONE;
                        xor_q   <= xor_q ^ in_byte;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for the instruction-memory loader.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        im_wr;
    logic [6:0]  im_addr;
    logic [15:0] im_data;
    logic        proc_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int cyc      = 0;

    logic [6:0]  wr_addr [0:511];
    logic [15:0] wr_data [0:511];

    imem_loader #(.ADDR_W(7), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .im_wr      (im_wr),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .proc_reset (proc_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // write monitor: strobe is stable mid-cycle
    always @(negedge clk) begin
        if (im_wr === 1'b1) begin
            if (n_wr < 512) begin
                wr_addr[n_wr] = im_addr;
                wr_data[n_wr] = im_data;
            end
            n_wr = n_wr + 1;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h never accepted", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit throttle,
                              input bit poke);
        foreach (f[i]) begin
            if (throttle) begin
                start = poke && (i > 0) && (i < f.size() - 1);
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(f[i]);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (im_wr !== 1'b0) begin n_fail++;
            $display("FAIL rst_im_wr: got %b want 0", im_wr); end
        n_checks++; if (im_addr !== 7'd0) begin n_fail++;
            $display("FAIL rst_im_addr: got %h want 0", im_addr); end
        n_checks++; if (im_data !== 16'h0000) begin n_fail++;
            $display("FAIL rst_im_data: got %h want 0", im_data); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++;
            $display("FAIL rst_proc_reset: got %b want 1", proc_reset); end
        n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++;
            $display("FAIL rst_flags: got done=%b error=%b want 0/0",
                     done, error); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL idle_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_program_load();
        int base;
        int c0;
        logic [7:0] f[$];
        f = '{8'h02, 8'h21, 8'hB1, 8'h50, 8'h00};
        base = n_wr;
        do_start();
        c0 = cyc;
        send_frame(f, 1'b0, 1'b0);
        n_checks++; if (proc_reset !== 1'b1 || done !== 1'b0) begin n_fail++;
            $display("FAIL load_pre_chk: got proc_reset=%b done=%b want 1/0",
                     proc_reset, done); end
        send_byte(8'hC2);
        n_checks++; if (cyc - c0 !== 6) begin n_fail++;
            $display("FAIL load_cycles: got %0d want 6", cyc - c0); end
        n_checks++; if (n_wr - base !== 2) begin n_fail++;
            $display("FAIL load_wr_count: got %0d want 2", n_wr - base); end
        n_checks++; if (wr_addr[base] !== 7'd0 || wr_data[base] !== 16'h21B1)
        begin n_fail++;
            $display("FAIL load_wr0: got %h/%h want 00/21b1",
                     wr_addr[base], wr_data[base]); end
        n_checks++;
        if (wr_addr[base+1] !== 7'd1 || wr_data[base+1] !== 16'h5000)
        begin n_fail++;
            $display("FAIL load_wr1: got %h/%h want 01/5000",
                     wr_addr[base+1], wr_data[base+1]); end
        n_checks++; if (proc_reset !== 1'b0) begin n_fail++;
            $display("FAIL load_proc_reset: got %b want 0", proc_reset); end
        n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++;
            $display("FAIL load_flags: got done=%b error=%b want 1/0",
                     done, error); end
        n_checks++; if (im_addr !== 7'd1 || im_data !== 16'h5000) begin
            n_fail++;
            $display("FAIL load_hold: got %h/%h want 01/5000",
                     im_addr, im_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL load_run_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_checksum_error();
        int base;
        logic [7:0] f[$];
        f = '{8'h02, 8'h21, 8'hB1, 8'h50, 8'h00, 8'hC3};
        base = n_wr;
        do_start();
        n_checks++; if (done !== 1'b0 || proc_reset !== 1'b1) begin n_fail++;
            $display("FAIL chk_restart: got done=%b proc_reset=%b want 0/1",
                     done, proc_reset); end
        send_frame(f, 1'b0, 1'b0);
        n_checks++; if (n_wr - base !== 2) begin n_fail++;
            $display("FAIL chk_wr_count: got %0d want 2", n_wr - base); end
        n_checks++;
        if (wr_data[base] !== 16'h21B1 || wr_data[base+1] !== 16'h5000)
        begin n_fail++;
            $display("FAIL chk_wr_data: got %h,%h want 21b1,5000",
                     wr_data[base], wr_data[base+1]); end
        n_checks++; if (error !== 1'b1 || done !== 1'b0) begin n_fail++;
            $display("FAIL chk_flags: got error=%b done=%b want 1/0",
                     error, done); end
        n_checks++; if (proc_reset !== 1'b1) begin n_fail++;
            $display("FAIL chk_proc_reset: got %b want 1", proc_reset); end
    endtask

    task automatic test_bad_count();
        int base;
        base = n_wr;
        do_start();
        n_checks++; if (error !== 1'b0) begin n_fail++;
            $display("FAIL badcnt_clear: got error=%b want 0", error); end
        send_byte(8'h81);
        n_checks++; if (error !== 1'b1) begin n_fail++;
            $display("FAIL badcnt_err: got error=%b want 1", error); end
        in_valid = 1'b1;
        in_byte  = 8'h12;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL badcnt_ready: got %b want 0", in_ready); end
        n_checks++; if (n_wr - base !== 0) begin n_fail++;
            $display("FAIL badcnt_wr: got %0d want 0", n_wr - base); end
        n_checks++; if (error !== 1'b1 || proc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL badcnt_hold: got error=%b proc_reset=%b want 1/1",
                     error, proc_reset); end
    endtask

    task automatic test_throttle();
        int base;
        logic [7:0] f[$];
        f = '{8'h02, 8'h21, 8'hB1, 8'h50, 8'h00, 8'hC2};
        base = n_wr;
        do_start();
        send_frame(f, 1'b1, 1'b1);
        n_checks++; if (n_wr - base !== 2) begin n_fail++;
            $display("FAIL thr_wr_count: got %0d want 2", n_wr - base); end
        n_checks++;
        if (wr_addr[base] !== 7'd0 || wr_data[base] !== 16'h21B1 ||
            wr_addr[base+1] !== 7'd1 || wr_data[base+1] !== 16'h5000)
        begin n_fail++;
            $display("FAIL thr_wr: got %h/%h %h/%h want 00/21b1 01/5000",
                     wr_addr[base], wr_data[base],
                     wr_addr[base+1], wr_data[base+1]); end
        n_checks++; if (done !== 1'b1 || proc_reset !== 1'b0) begin n_fail++;
            $display("FAIL thr_done: got done=%b proc_reset=%b want 1/0",
                     done, proc_reset); end
    endtask

    task automatic test_full_memory();
        int base;
        logic [7:0] f[$];
        logic [7:0] chk;
        logic [7:0] hb;
        f.delete();
        f.push_back(8'h00);
        chk = 8'h00;
        for (int i = 0; i < 128; i++) begin
            hb = 8'(i);
            f.push_back(hb);
            f.push_back(hb ^ 8'hA5);
            chk = chk ^ hb ^ (hb ^ 8'hA5);
        end
        f.push_back(chk);
        base = n_wr;
        do_start();
        send_frame(f, 1'b0, 1'b0);
        n_checks++; if (n_wr - base !== 128) begin n_fail++;
            $display("FAIL full_wr_count: got %0d want 128", n_wr - base); end
        for (int i = 0; i < 128; i++) begin
            hb = 8'(i);
            n_checks++;
            if (wr_addr[base+i] !== 7'(i) ||
                wr_data[base+i] !== {hb, hb ^ 8'hA5}) begin
                n_fail++;
                $display("FAIL full_wr%0d: got %h/%h want %h/%h", i,
                         wr_addr[base+i], wr_data[base+i], 7'(i),
                         {hb, hb ^ 8'hA5});
            end
        end
        n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++;
            $display("FAIL full_done: got done=%b error=%b want 1/0",
                     done, error); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        logic [7:0] f[$];
        f = '{8'h02, 8'h21, 8'hB1, 8'h50};
        base = n_wr;
        do_start();
        send_frame(f, 1'b0, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'h00;
        @(negedge clk);
        n_checks++; if (proc_reset !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got proc_reset=%b in_ready=%b want 1/0",
                     proc_reset, in_ready); end
        n_checks++; if (im_wr !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_wr: got %b want 0", im_wr); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (n_wr - base !== 1) begin n_fail++;
            $display("FAIL mid_wr_count: got %0d want 1", n_wr - base); end
        n_checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin n_fail++;
            $display("FAIL mid_idle: got in_ready=%b done=%b want 0/0",
                     in_ready, done); end
        base = n_wr;
        f = '{8'h01, 8'hDE, 8'hAD, 8'h72};
        do_start();
        send_frame(f, 1'b0, 1'b0);
        n_checks++;
        if (n_wr - base !== 1 || wr_addr[base] !== 7'd0 ||
            wr_data[base] !== 16'hDEAD) begin
            n_fail++;
            $display("FAIL mid_reload_wr: got n=%0d %h/%h want 1 00/dead",
                     n_wr - base, wr_addr[base], wr_data[base]); end
        n_checks++; if (done !== 1'b1 || proc_reset !== 1'b0) begin n_fail++;
            $display("FAIL mid_reload_done: got done=%b proc_reset=%b want 1/0",
                     done, proc_reset); end
    endtask

    initial begin
        test_reset();
        test_program_load();
        test_checksum_error();
        test_bad_count();
        test_throttle();
        test_full_memory();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
